// File: rtl/tri_edge_diff_if.sv
// Handshake and data bundle for tri_edge_diff: vertex input side, edge-difference output side.
interface tri_edge_diff_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x1, y1, x2, y2, x3, y3;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] diff_x1x2, diff_x2x3, diff_x3x1;
  logic [31:0] diff_y1y2, diff_y2y3, diff_y3y1;
  logic [31:0] vx1_o, vy1_o, vx2_o, vy2_o, vx3_o, vy3_o;
  logic        busy;

  modport master (
    output in_valid, x1, y1, x2, y2, x3, y3, out_ready,
    input  in_ready, out_valid, busy,
    input  diff_x1x2, diff_x2x3, diff_x3x1, diff_y1y2, diff_y2y3, diff_y3y1,
    input  vx1_o, vy1_o, vx2_o, vy2_o, vx3_o, vy3_o
  );

  modport slave (
    input  in_valid, x1, y1, x2, y2, x3, y3, out_ready,
    output in_ready, out_valid, busy,
    output diff_x1x2, diff_x2x3, diff_x3x1, diff_y1y2, diff_y2y3, diff_y3y1,
    output vx1_o, vy1_o, vx2_o, vy2_o, vx3_o, vy3_o
  );
endinterface

// File: rtl/tri_edge_diff.sv
// Triangle-setup edge differences: six float32 subtractions on one shared 4-stage subtractor.
// Build macro TRI_EDGE_DIFF_ROUND_EN selects round-to-nearest-even; otherwise results truncate.
module tri_edge_diff #(
  parameter int PASS_VERTS = 1
) (
  input logic            clk,
  input logic            rst,
  tri_edge_diff_if.slave bus
);
  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, PACK, DONE} state_t;

  state_t           state;
  logic [2:0]       k;
  logic [5:0][31:0] vert;   // x1,x2,x3,y1,y2,y3
  logic [5:0][31:0] diff;   // x1x2,x2x3,x3x1,y1y2,y2y3,y3y1
  logic             in_ready_r, out_valid_r, busy_r;

  logic              r_sign, r_sub, r_special;
  logic signed [9:0] r_exp;
  logic [26:0]       r_ma, r_mb, r_man;
  logic [27:0]       r_sum;

  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic [4:0] n;
    n = 5'd27;
    for (int unsigned i = 0; i < 27; i++)
      if (v[i]) n = 5'(26 - i);
    return n;
  endfunction

  logic [31:0] opa, opb;
  always_comb begin
    opa = vert[0];
    opb = vert[1];
    case (k)
      3'd1: begin opa = vert[1]; opb = vert[2]; end
      3'd2: begin opa = vert[2]; opb = vert[0]; end
      3'd3: begin opa = vert[3]; opb = vert[4]; end
      3'd4: begin opa = vert[4]; opb = vert[5]; end
      3'd5: begin opa = vert[5]; opb = vert[3]; end
      default: ;
    endcase
  end

  // a-b as a+(-b); denormals flushed; larger magnitude routed to the A side
  logic        sa, sb, a_ge_b, special, bs;
  logic [7:0]  ea, eb, be, le, d;
  logic [23:0] ma, mb, bm, lm;
  logic [49:0] wide;
  logic [26:0] lm_al;
  always_comb begin
    sa      = opa[31];
    sb      = ~opb[31];
    ea      = opa[30:23];
    eb      = opb[30:23];
    ma      = (ea == '0) ? '0 : {1'b1, opa[22:0]};
    mb      = (eb == '0) ? '0 : {1'b1, opb[22:0]};
    special = (ea == '1) || (eb == '1);
    a_ge_b  = {ea, ma} >= {eb, mb};
    bs      = a_ge_b ? sa : sb;
    be      = a_ge_b ? ea : eb;
    bm      = a_ge_b ? ma : mb;
    le      = a_ge_b ? eb : ea;
    lm      = a_ge_b ? mb : ma;
    d       = be - le;
    wide    = {lm, 26'b0} >> d;
    lm_al   = (d >= 8'd26) ? {26'b0, |lm} : {wide[49:24], |wide[23:0]};
  end

  logic [4:0] lz;
  always_comb lz = lzc27(r_sum[26:0]);

  logic [24:0]       rnd;
  logic signed [9:0] pexp;
  logic [22:0]       frac;
  logic [31:0]       res;
  always_comb begin
`ifdef TRI_EDGE_DIFF_ROUND_EN
    rnd = {1'b0, r_man[26:3]} + 25'(r_man[2] & (r_man[1] | r_man[0] | r_man[3]));
`else
    rnd = {1'b0, r_man[26:3]};
`endif
    pexp = r_exp;
    frac = rnd[22:0];
    if (rnd[24]) begin
      pexp = r_exp + 10'sd1;
      frac = rnd[23:1];
    end
    if (r_special)            res = 32'h7FC0_0000;
    else if (r_man == '0)     res = 32'h0;
    else if (pexp <= 10'sd0)  res = {r_sign, 31'b0};
    else if (pexp >= 10'sd255) res = {r_sign, 8'hFF, 23'b0};
    else                      res = {r_sign, pexp[7:0], frac};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      k           <= '0;
      vert        <= '0;
      diff        <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      r_sign      <= 1'b0;
      r_sub       <= 1'b0;
      r_special   <= 1'b0;
      r_exp       <= '0;
      r_ma        <= '0;
      r_mb        <= '0;
      r_man       <= '0;
      r_sum       <= '0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          vert       <= {bus.y3, bus.y2, bus.y1, bus.x3, bus.x2, bus.x1};
          k          <= '0;
          in_ready_r <= 1'b0;
          busy_r     <= 1'b1;
          state      <= ALIGN;
        end
        ALIGN: begin
          r_sign    <= bs;
          r_sub     <= sa ^ sb;
          r_special <= special;
          r_exp     <= {2'b00, be};
          r_ma      <= {bm, 3'b000};
          r_mb      <= lm_al;
          state     <= ADD;
        end
        ADD: begin
          r_sum <= r_sub ? ({1'b0, r_ma} - {1'b0, r_mb}) : ({1'b0, r_ma} + {1'b0, r_mb});
          state <= NORM;
        end
        NORM: begin
          if (r_sum[27]) begin
            r_man <= {r_sum[27:2], r_sum[1] | r_sum[0]};
            r_exp <= r_exp + 10'sd1;
          end else begin
            r_man <= r_sum[26:0] << lz;
            r_exp <= r_exp - 10'({5'b0, lz});
          end
          state <= PACK;
        end
        PACK: begin
          diff[k] <= res;
          if (k == 3'd5) begin
            out_valid_r <= 1'b1;
            state       <= DONE;
          end else begin
            k     <= k + 3'd1;
            state <= ALIGN;
          end
        end
        DONE: if (bus.out_ready) begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          busy_r      <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.busy      = busy_r;
  assign bus.diff_x1x2 = diff[0];
  assign bus.diff_x2x3 = diff[1];
  assign bus.diff_x3x1 = diff[2];
  assign bus.diff_y1y2 = diff[3];
  assign bus.diff_y2y3 = diff[4];
  assign bus.diff_y3y1 = diff[5];

  generate
    if (PASS_VERTS != 0) begin : g_pass
      assign bus.vx1_o = vert[0];
      assign bus.vx2_o = vert[1];
      assign bus.vx3_o = vert[2];
      assign bus.vy1_o = vert[3];
      assign bus.vy2_o = vert[4];
      assign bus.vy3_o = vert[5];
    end else begin : g_nopass
      assign bus.vx1_o = '0;
      assign bus.vx2_o = '0;
      assign bus.vx3_o = '0;
      assign bus.vy1_o = '0;
      assign bus.vy2_o = '0;
      assign bus.vy3_o = '0;
    end
  endgenerate
endmodule
